router_pkt_tx: RTL and testbench
================================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 start  in  1  request to send one packet; sampled only in IDLE.
REQ-004 addr  in  2  destination port 0..2; value 3 is invalid.
REQ-005 len  in  6  payload length in bytes, 1..63; 0 is invalid.
REQ-006 pl_data  in  8  payload byte from show-ahead source; valid in any cycle pl_req is high.
REQ-007 pl_req  out  1  pop strobe; pl_data is consumed at the rising edge ending a cycle with pl_req=1.
REQ-008 busy  in  1  router backpressure; the byte on data_out is not accepted in a cycle with busy=1.
REQ-009 data_out  out  8  router input byte (registered).
REQ-010 pkt_valid  out  1  high while header/payload on data_out (registered).
REQ-011 ready  out  1  high only in IDLE.
REQ-012 tx_done  out  1  one-cycle pulse when parity byte accepted.
REQ-013 reject  out  1  one-cycle pulse when start rejected.
REQ-014 pkt_cnt  out  8  count of completed packets; wraps 255->0.

Function
REQ-015 FSM states: IDLE, HEADER, PAYLOAD, PARITY, GAP; state register only.
REQ-016 Accept rule: bus byte accepted at a rising edge where state is HEADER/PAYLOAD/PARITY and busy=0.
REQ-017 IDLE, start=1, addr!=3, len!=0: latch addr/len; next cycle HEADER, data_out={len,addr}, pkt_valid=1 (latency 1).
REQ-018 IDLE, start=1, addr==3 or len==0: stay IDLE, reject=1 next cycle, bus unchanged.
REQ-019 Any state with busy=1: data_out, pkt_valid, state, counters held; pl_req=0.
REQ-020 HEADER accepted: -> PAYLOAD; pl_req=1 that cycle; data_out<=pl_data, pkt_valid stays 1.
REQ-021 PAYLOAD: remaining-byte counter (6 bits) loads len at start, decrements per accepted payload byte.
REQ-022 PAYLOAD accepted with remaining>1: pl_req=1, data_out<=pl_data.
REQ-023 PAYLOAD accepted with remaining==1: -> PARITY; pl_req=0; data_out<=parity; pkt_valid<=0.
REQ-024 Parity: 8-bit XOR of header and all payload bytes; cleared on entry to HEADER; updated per accepted byte.
REQ-025 PARITY accepted: -> GAP; tx_done=1 next cycle; pkt_cnt+1; data_out<=0.
REQ-026 GAP: exactly one cycle, pkt_valid=0, busy ignored; -> IDLE.
REQ-027 start while not IDLE: ignored, not queued.
REQ-028 pl_req never high in IDLE, PARITY, GAP, or while busy=1; exactly len pops per packet.
REQ-029 pkt_valid is low in IDLE, PARITY, GAP.

Reset
REQ-030 rst=1: state IDLE, data_out=0, pkt_valid=0, pl_req=0, tx_done=0, reject=0, pkt_cnt=0, parity=0, counter=0.
REQ-031 rst mid-packet: aborts at that edge; no tx_done; pkt_cnt not incremented; no further pl_req.
REQ-032 rst takes priority over start and busy in the same cycle.

Verification
REQ-033 addr=1, len=3, payload 11,22,33, busy=0 -> data_out 0D,11,22,33 (pkt_valid=1), then 0D (pkt_valid=0), tx_done, pkt_cnt=1; 6 cycles start-to-IDLE.
REQ-034 Same packet, busy=1 for 2 cycles on 2nd payload byte -> 22 held 3 cycles, no pl_req during busy, parity still 0D.
REQ-035 start with addr=3 or len=0 -> reject pulse, pkt_valid stays 0, no pl_req.
REQ-036 len=63, addr=2 -> header FE, 63 pops, parity = FE XOR payloads, pkt_valid high 64 cycles.
REQ-037 rst asserted during PAYLOAD -> next cycle IDLE, outputs zero, pkt_cnt unchanged; new packet sends correctly.
REQ-038 256 back-to-back len=1 packets -> pkt_cnt wraps to 0, one GAP cycle between packets.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding a router port: header {len,addr}, len payload bytes
// pulled from a show-ahead source, then an XOR parity byte and one idle gap cycle.
module router_pkt_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] addr,
  input  logic [5:0] len,
  input  logic [7:0] pl_data,
  output logic       pl_req,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       ready,
  output logic       tx_done,
  output logic       reject,
  output logic [7:0] pkt_cnt,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] data_nxt;
  logic       pv_nxt;
  logic       done_nxt;
  logic       rej_nxt;
  logic [7:0] cnt_nxt;
  logic [7:0] parity, par_nxt;
  logic [5:0] rem_cnt, rem_nxt;
  logic       accept;

  // Handshake: the byte on data_out is taken at a rising edge in HEADER/PAYLOAD/PARITY
  // with busy=0; pl_req pops pl_data at that same edge, so it is only raised when
  // the current bus byte is being accepted and another payload byte is still owed.
  assign accept    = !busy;
  assign ready     = (state == S_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    data_nxt  = data_out;
    pv_nxt    = pkt_valid;
    done_nxt  = 1'b0;
    rej_nxt   = 1'b0;
    cnt_nxt   = pkt_cnt;
    par_nxt   = parity;
    rem_nxt   = rem_cnt;
    pl_req    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (addr != 2'd3 && len != 6'd0) begin
            state_nxt = S_HEADER;
            data_nxt  = {len, addr};
            pv_nxt    = 1'b1;
            par_nxt   = 8'h00;
            rem_nxt   = len;
          end else begin
            rej_nxt = 1'b1;
          end
        end
      end
      S_HEADER: begin
        if (accept) begin
          pl_req    = 1'b1;
          par_nxt   = parity ^ data_out;
          data_nxt  = pl_data;
          state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          par_nxt = parity ^ data_out;
          rem_nxt = rem_cnt - 6'd1;
          if (rem_cnt > 6'd1) begin
            pl_req   = 1'b1;
            data_nxt = pl_data;
          end else begin
            // Last payload byte leaves now: the parity byte must include it.
            state_nxt = S_PARITY;
            data_nxt  = parity ^ data_out;
            pv_nxt    = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (accept) begin
          state_nxt = S_GAP;
          done_nxt  = 1'b1;
          cnt_nxt   = pkt_cnt + 8'd1;
          data_nxt  = 8'h00;
        end
      end
      S_GAP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      data_out  <= 8'h00;
      pkt_valid <= 1'b0;
      tx_done   <= 1'b0;
      reject    <= 1'b0;
      pkt_cnt   <= 8'h00;
      parity    <= 8'h00;
      rem_cnt   <= 6'd0;
    end else begin
      state     <= state_nxt;
      data_out  <= data_nxt;
      pkt_valid <= pv_nxt;
      tx_done   <= done_nxt;
      reject    <= rej_nxt;
      pkt_cnt   <= cnt_nxt;
      parity    <= par_nxt;
      rem_cnt   <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: expected bus bytes are queued per packet and
// compared cycle by cycle; a show-ahead payload memory models the source.
module tb_router_pkt_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] addr;
  logic [5:0] len;
  logic [7:0] pl_data;
  logic       pl_req;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       ready;
  logic       tx_done;
  logic       reject;
  logic [7:0] pkt_cnt;
  logic [2:0] dbg_state;

  router_pkt_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr      (addr),
    .len       (len),
    .pl_data   (pl_data),
    .pl_req    (pl_req),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .ready     (ready),
    .tx_done   (tx_done),
    .reject    (reject),
    .pkt_cnt   (pkt_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // show-ahead payload source
  logic [7:0] src_mem [256];
  logic [7:0] rd_ptr  = 8'h00;
  int         pop_cnt = 0;
  int         bad_preq = 0;

  assign pl_data = src_mem[rd_ptr];

  always @(posedge clk) begin
    if (pl_req) begin
      rd_ptr  <= rd_ptr + 8'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (pl_req && (busy || !(dbg_state == 3'd1 || dbg_state == 3'd2)))
      bad_preq <= bad_preq + 1;
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] pay [64];
  logic [7:0] exp_cnt = 8'h00;
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'h00;
  endtask

  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l,
                          input int stall_idx, input int stall_cyc, input bit gap_busy);
    logic [7:0] par;
    logic [7:0] b;
    int         pops0;
    int         idx;
    int         cyc;
    int         extra;
    exp_q.delete();
    par = {l, a};
    exp_q.push_back({l, a});
    for (int i = 0; i < int'(l); i++) begin
      b = pay[i];
      src_mem[rd_ptr + 8'(i)] = b;
      exp_q.push_back(b);
      par ^= b;
    end
    pops0 = pop_cnt;
    idx   = 0;
    cyc   = 0;
    extra = 0;
    addr  = a;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc++;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      chk("bus_byte", 32'(data_out), 32'(b));
      chk("pkt_valid_hi", 32'(pkt_valid), 1);
      if (idx == stall_idx) begin
        busy  = 1'b1;
        start = 1'b1;
        for (int s = 0; s < stall_cyc; s++) begin
          @(negedge clk);
          cyc++;
          extra++;
          chk("stall_hold", 32'(data_out), 32'(b));
          chk("stall_preq", 32'(pl_req), 0);
        end
        busy  = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      idx++;
    end
    chk("parity_byte", 32'(data_out), 32'(par));
    chk("parity_pv", 32'(pkt_valid), 0);
    chk("parity_preq", 32'(pl_req), 0);
    @(negedge clk);
    cyc++;
    exp_cnt = exp_cnt + 8'd1;
    chk("gap_done", 32'(tx_done), 1);
    chk("gap_data", 32'(data_out), 0);
    chk("gap_pv", 32'(pkt_valid), 0);
    chk("gap_cnt", 32'(pkt_cnt), 32'(exp_cnt));
    if (gap_busy) busy = 1'b1;
    @(negedge clk);
    cyc++;
    busy = 1'b0;
    chk("idle_ready", 32'(ready), 1);
    chk("idle_done", 32'(tx_done), 0);
    chk("pop_count", 32'(pop_cnt - pops0), 32'(l));
    chk("pkt_cycles", 32'(cyc - 1), 32'(int'(l) + 3 + extra));
  endtask

  task automatic try_reject(input logic [1:0] a, input logic [5:0] l);
    int pops0;
    pops0 = pop_cnt;
    addr  = a;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej_pulse", 32'(reject), 1);
    chk("rej_pv", 32'(pkt_valid), 0);
    chk("rej_ready", 32'(ready), 1);
    chk("rej_data", 32'(data_out), 0);
    @(negedge clk);
    chk("rej_clear", 32'(reject), 0);
    chk("rej_pops", 32'(pop_cnt - pops0), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    addr  = 2'd0;
    len   = 6'd0;
    busy  = 1'b0;
    for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) pay[i] = 8'h00;
    @(negedge clk);
    do_reset();

    chk("rst_data", 32'(data_out), 0);
    chk("rst_pv", 32'(pkt_valid), 0);
    chk("rst_preq", 32'(pl_req), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_cnt", 32'(pkt_cnt), 0);
    chk("rst_ready", 32'(ready), 1);

    try_reject(2'd3, 6'd4);
    try_reject(2'd1, 6'd0);

    // reset in the middle of a payload aborts the packet
    pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3; pay[3] = 8'hA4; pay[4] = 8'hA5;
    for (int i = 0; i < 5; i++) src_mem[rd_ptr + 8'(i)] = pay[i];
    addr = 2'd1; len = 6'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_byte", 32'(data_out), 32'h0000_00A2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 1);
    chk("abort_data", 32'(data_out), 0);
    chk("abort_pv", 32'(pkt_valid), 0);
    chk("abort_preq", 32'(pl_req), 0);
    chk("abort_done", 32'(tx_done), 0);
    chk("abort_cnt", 32'(pkt_cnt), 0);
    @(negedge clk);
    chk("abort_idle", 32'(ready), 1);
    chk("abort_nodone", 32'(tx_done), 0);

    // reset wins over start and busy in the same cycle
    rst = 1'b1; start = 1'b1; busy = 1'b1; addr = 2'd0; len = 6'd2;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; busy = 1'b0;
    chk("rst_prio_ready", 32'(ready), 1);
    chk("rst_prio_pv", 32'(pkt_valid), 0);

    // addr=1 len=3: header 0D, parity 0D
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_pkt(2'd1, 6'd3, -1, 0, 1'b0);
    chk("cnt_one", 32'(pkt_cnt), 1);

    // same packet, 2-cycle stall on 2nd payload byte, start held while busy
    send_pkt(2'd1, 6'd3, 2, 2, 1'b1);

    // maximum length, addr=2: header FE
    for (int i = 0; i < 63; i++) pay[i] = 8'(i * 7 + 3);
    send_pkt(2'd2, 6'd63, 10, 1, 1'b0);

    // 256 back-to-back single-byte packets wrap the counter
    do_reset();
    for (int k = 0; k < 256; k++) begin
      pay[0] = 8'(k * 5 + 1);
      send_pkt(2'(k % 3), 6'd1, -1, 0, (k == 5));
    end
    chk("cnt_wrap", 32'(pkt_cnt), 0);
    chk("no_bad_preq", 32'(bad_preq), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
